// File: rtl/seq_pkg.sv
// Shared types and opcode constants for the 4-bit CPU program sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_LI   = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b111;

endpackage

// File: rtl/seq_prog_mem.sv
// Instruction store: one synchronous write port, one combinational read port.
// Deliberately unreset so a loaded program survives RST_N.
module seq_prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int IW    = 9
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [IW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [IW-1:0] rdata_o
);

  logic [IW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_sequencer.sv
// Run/halt controller stepping a PC through program memory, one instruction per
// FETCH/HIGH/LOW slot. Define SEQ_LOOP_EN to wrap the PC at len instead of ending.
module cpu_sequencer
  import seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int IW    = 9
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          LoadEn,
  input  logic [AW-1:0] LoadAddr,
  input  logic [IW-1:0] LoadData,
  input  logic [AW:0]   ProgLen,
  input  logic          Start,
  input  logic          Stop,
  output logic [IW-1:0] Instruction,
  output logic          CpuClk,
  output logic          Busy,
  output logic          Done,
  output logic [AW-1:0] PC,
  output logic [7:0]    IssueCount
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  seq_state_e    state_q;
  logic [AW:0]   len_q;
  logic [AW-1:0] pc_q;
  logic [7:0]    issue_cnt_q;
  logic [7:0]    issue_cnt_d;
  logic [IW-1:0] instr_q;
  logic          cpu_clk_q;
  logic          busy_q;
  logic          done_q;
  logic          stop_pend_q;

  logic [IW-1:0] mem_rdata;
  logic [AW:0]   len_sat;
  logic [AW:0]   pc_inc;
  logic          last_instr;
  logic          stop_now;
  logic          is_halt;

  // Loads are gated by the registered Busy so a run never sees its program change.
  seq_prog_mem #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) u_mem (
    .clk_i   (CLK),
    .we_i    (LoadEn & ~busy_q),
    .waddr_i (LoadAddr),
    .wdata_i (LoadData),
    .raddr_i (pc_q),
    .rdata_o (mem_rdata)
  );

  assign len_sat     = (ProgLen > DEPTH_W) ? DEPTH_W : ProgLen;
  assign pc_inc      = {1'b0, pc_q} + (AW+1)'(1);
  assign last_instr  = (pc_inc == len_q);
  assign stop_now    = stop_pend_q | Stop;
  assign is_halt     = (mem_rdata[IW-1 -: 3] == OP_HALT);
  assign issue_cnt_d = (issue_cnt_q == 8'hFF) ? issue_cnt_q : issue_cnt_q + 8'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      len_q       <= '0;
      pc_q        <= '0;
      issue_cnt_q <= '0;
      instr_q     <= '0;
      cpu_clk_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            len_q       <= len_sat;
            pc_q        <= '0;
            issue_cnt_q <= '0;
            stop_pend_q <= Stop;
            busy_q      <= 1'b1;
            if (len_sat == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        FETCH: begin
          instr_q <= mem_rdata;
          if (stop_now || is_halt) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q   <= HIGH;
            cpu_clk_q <= 1'b1;
          end
        end
        HIGH: begin
          if (Stop) stop_pend_q <= 1'b1;
          cpu_clk_q <= 1'b0;
          state_q   <= LOW;
        end
        LOW: begin
          issue_cnt_q <= issue_cnt_d;
          if (stop_now) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (last_instr) begin
`ifdef SEQ_LOOP_EN
            pc_q    <= '0;
            state_q <= FETCH;
`else
            state_q <= DONE;
            done_q  <= 1'b1;
`endif
          end else begin
            pc_q    <= pc_q + AW'(1);
            state_q <= FETCH;
          end
        end
        DONE: begin
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          stop_pend_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Instruction = instr_q;
  assign CpuClk      = cpu_clk_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign PC          = pc_q;
  assign IssueCount  = issue_cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench: stimulus queues the expected issued instructions and Done
// summaries; a negedge monitor pops and compares them as the DUT produces them.
module tb_cpu_sequencer;

  localparam int AW = 4;
  localparam int IW = 9;

  typedef struct {
    logic [7:0]    cnt;
    logic [AW-1:0] pc;
    int            cyc;
  } done_exp_t;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          LoadEn = 1'b0;
  logic [AW-1:0] LoadAddr = '0;
  logic [IW-1:0] LoadData = '0;
  logic [AW:0]   ProgLen = '0;
  logic          Start = 1'b0;
  logic          Stop = 1'b0;
  logic [IW-1:0] Instruction;
  logic          CpuClk;
  logic          Busy;
  logic          Done;
  logic [AW-1:0] PC;
  logic [7:0]    IssueCount;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  logic cpuclk_prev = 1'b0;

  logic [IW-1:0] inst_q[$];
  done_exp_t     done_q[$];
  logic [IW-1:0] mem_m [16];

  cpu_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .LoadEn(LoadEn), .LoadAddr(LoadAddr),
    .LoadData(LoadData), .ProgLen(ProgLen), .Start(Start), .Stop(Stop),
    .Instruction(Instruction), .CpuClk(CpuClk), .Busy(Busy), .Done(Done),
    .PC(PC), .IssueCount(IssueCount)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor
  always @(negedge CLK) begin
    if (RST_N) begin
      if (CpuClk && !cpuclk_prev) begin
        n_cmp++;
        if (inst_q.size() == 0) begin
          n_err++;
          $display("FAIL cpuclk_rise: unexpected rise at cycle %0d, instr=%b", cyc, Instruction);
        end else begin
          logic [IW-1:0] e;
          e = inst_q.pop_front();
          if (Instruction !== e) begin
            n_err++;
            $display("FAIL instr: got %b expected %b at cycle %0d", Instruction, e, cyc);
          end else
            $display("issue  instr=%b cycle=%0d ok", Instruction, cyc);
        end
      end
      if (Done) begin
        n_cmp++;
        if (done_q.size() == 0) begin
          n_err++;
          $display("FAIL done: unexpected Done at cycle %0d", cyc);
        end else begin
          done_exp_t d;
          d = done_q.pop_front();
          if (IssueCount !== d.cnt || PC !== d.pc || cyc != d.cyc) begin
            n_err++;
            $display("FAIL done: got cnt=%0d pc=%0d cyc=%0d expected cnt=%0d pc=%0d cyc=%0d",
                     IssueCount, PC, cyc, d.cnt, d.pc, d.cyc);
          end else
            $display("done   cnt=%0d pc=%0d cycle=%0d ok", IssueCount, PC, cyc);
        end
      end
    end
    cpuclk_prev = CpuClk;
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else
      $display("check  %s=%0h ok", name, got);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d);
    @(posedge CLK); #1;
    LoadEn = 1'b1; LoadAddr = a; LoadData = d;
    mem_m[a] = d;
    @(posedge CLK); #1;
    LoadEn = 1'b0;
  endtask

  // Start cycle is s; Done is expected at s + lat.
  task automatic start_run(input logic [AW:0] len, input logic stp,
                           input logic [7:0] cnt, input logic [AW-1:0] pc, input int lat);
    done_exp_t d;
    @(posedge CLK); #1;
    ProgLen = len; Start = 1'b1; Stop = stp;
    start_cyc = cyc;
    d.cnt = cnt; d.pc = pc; d.cyc = cyc + lat;
    done_q.push_back(d);
    @(posedge CLK); #1;
    Start = 1'b0; Stop = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 200; i++) begin
      @(posedge CLK); #1;
      if (done_q.size() == 0 && !Busy) break;
    end
    n_cmp++;
    if (done_q.size() != 0 || Busy) begin
      n_err++;
      $display("FAIL run_timeout: done pending=%0d busy=%0b", done_q.size(), Busy);
      done_q.delete();
    end
    n_cmp++;
    if (inst_q.size() != 0) begin
      n_err++;
      $display("FAIL cpuclk_count: %0d expected issues never seen", inst_q.size());
      inst_q.delete();
    end
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("rst_instr", 16'(Instruction), 16'h0);
    check("rst_cpuclk", 16'(CpuClk), 16'h0);
    check("rst_busy", 16'(Busy), 16'h0);
    check("rst_done", 16'(Done), 16'h0);
    check("rst_pc", 16'(PC), 16'h0);
    check("rst_cnt", 16'(IssueCount), 16'h0);
    @(negedge CLK); RST_N = 1'b1;

    // Basic three-instruction program: Done at Start+10 (cycle 11 counting Start as 1)
    load(4'd0, 9'b101011101);
    load(4'd1, 9'b101010110);
    load(4'd2, 9'b001011011);
    for (int i = 0; i < 3; i++) inst_q.push_back(mem_m[i]);
    start_run(5'd3, 1'b0, 8'd3, 4'd2, 10);
    wait_done();

    // Zero-length run
    start_run(5'd0, 1'b0, 8'd0, 4'd0, 1);
    wait_done();

    // HALT at address 1 ends the run after one issue
    load(4'd1, 9'b111000000);
    inst_q.push_back(mem_m[0]);
    start_run(5'd4, 1'b0, 8'd1, 4'd1, 5);
    wait_done();

    // Start and Stop together: first FETCH goes straight to DONE
    start_run(5'd3, 1'b1, 8'd0, 4'd0, 2);
    wait_done();

    // Stop during HIGH of instruction 2 of 5
    load(4'd1, 9'b000001010);
    load(4'd3, 9'b011100001);
    load(4'd4, 9'b100010011);
    inst_q.push_back(mem_m[0]);
    inst_q.push_back(mem_m[1]);
    start_run(5'd5, 1'b0, 8'd2, 4'd1, 7);
    repeat (4) @(posedge CLK);
    #1;
    check("stop_in_high", 16'(CpuClk), 16'h1);
    Stop = 1'b1;
    @(posedge CLK); #1;
    Stop = 1'b0;
    wait_done();

    // Loads and Start while Busy are ignored
    for (int i = 0; i < 3; i++) inst_q.push_back(mem_m[i]);
    start_run(5'd3, 1'b0, 8'd3, 4'd2, 10);
    LoadEn = 1'b1; LoadAddr = 4'd0; LoadData = 9'b010101010;
    @(posedge CLK); #1;
    LoadEn = 1'b0;
    @(posedge CLK); #1;
    Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    wait_done();
    inst_q.push_back(mem_m[0]);
    start_run(5'd1, 1'b0, 8'd1, 4'd0, 4);
    wait_done();

    // Asynchronous reset during HIGH
    ProgLen = 5'd3; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    for (int i = 0; i < 10 && !CpuClk; i++) begin
      @(posedge CLK); #1;
    end
    check("pre_rst_high", 16'(CpuClk), 16'h1);
    #1 RST_N = 1'b0;
    #1;
    check("arst_cpuclk", 16'(CpuClk), 16'h0);
    check("arst_busy", 16'(Busy), 16'h0);
    check("arst_instr", 16'(Instruction), 16'h0);
    check("arst_pc", 16'(PC), 16'h0);
    check("arst_cnt", 16'(IssueCount), 16'h0);
    @(negedge CLK); RST_N = 1'b1;
    inst_q.push_back(mem_m[0]);
    inst_q.push_back(mem_m[1]);
    start_run(5'd2, 1'b0, 8'd2, 4'd1, 7);
    wait_done();

    // Full memory with ProgLen above DEPTH saturates to 16 and does not wrap
    for (int i = 0; i < 16; i++) load(4'(i), {3'(i % 7), 6'(i * 5)});
    for (int i = 0; i < 16; i++) inst_q.push_back(mem_m[i]);
    start_run(5'd17, 1'b0, 8'd16, 4'd15, 49);
    wait_done();

    repeat (3) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Program sequencer for the 4-bit CPU. It holds a small instruction memory, steps a program counter through it, and drives the CPU's `Instruction` and `CLK` inputs, one instruction per three-phase issue slot. It replaces the hand-written testbench stimulus with a synthesizable run/halt controller. The CPU clock it produces is a derived phase signal, generated entirely within the sequencer's own `CLK` domain.

## Interface
- `DEPTH`, 16: instruction memory entries.
- `AW`, 4: address width; `DEPTH` = 2**`AW`.
- `IW`, 9: instruction width (3-bit opcode, 6-bit operand field).
- `CLK` in 1: single system clock, rising-edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `LoadEn` in 1: write `LoadData` to `mem[LoadAddr]` this cycle; honoured only when `Busy`=0.
- `LoadAddr` in `AW`: load address.
- `LoadData` in `IW`: load data.
- `ProgLen` in `AW`+1: number of instructions to run. Sampled on `Start`. Values above `DEPTH` are saturated to `DEPTH`.
- `Start` in 1: level-sampled; starts a run from PC=0 when in IDLE.
- `Stop` in 1: requests an early halt at the next instruction boundary.
- `Instruction` out `IW`: registered instruction presented to the CPU.
- `CpuClk` out 1: registered CPU clock phase.
- `Busy` out 1: high in any state except IDLE.
- `Done` out 1: one-cycle pulse at the end of a run.
- `PC` out `AW`: current program counter.
- `IssueCount` out 8: instructions completed in the current or last run. Saturates at 255.

## Operation
- States and transitions:
  - IDLE: on `Start`, latch `ProgLen`, set PC=0, clear `IssueCount`, then go to FETCH. If the latched `ProgLen`=0, go to DONE instead.
  - FETCH: `Instruction`<=`mem[PC]`, `CpuClk`=0. If `mem[PC][8:6]`==`OP_HALT` (3'b111), go to DONE without issuing; otherwise go to HIGH.
  - HIGH: `CpuClk`=1. The CPU latches its instruction register on this rising edge.
  - LOW: `CpuClk`=0. This falling edge is the CPU's write-back. Increment `IssueCount`. If PC+1==len or a stop is pending, go to DONE. Otherwise PC<=PC+1 and go to FETCH.
  - DONE: `Done`=1 for one cycle, then IDLE.
- `Stop` is sampled in FETCH, HIGH and LOW, and is latched as `stop_pend`:
  - Asserted in FETCH: go to DONE without issuing.
  - Asserted in HIGH: the current instruction completes through LOW before halting. Half-issued instructions are never produced.
- `Start` while `Busy` is ignored. `LoadEn` while `Busy` is ignored; memory is unchanged.
- Simultaneous `Start` and `Stop` in IDLE: `Start` wins, and `stop_pend` is set. The first FETCH then goes straight to DONE with `IssueCount`=0.
- PC arithmetic is `AW` bits. With `ProgLen`=`DEPTH`, the run ends at PC=`DEPTH`-1 and never wraps (except under `SEQ_LOOP_EN`).
- Instruction memory is not reset; its contents survive `RST_N`.

## Timing
- Reset values: `Instruction`=0, `CpuClk`=0, `Busy`=0, `Done`=0, `PC`=0, `IssueCount`=0, state=IDLE, `stop_pend`=0.
- `Start` to the first `CpuClk` rise: 2 cycles (IDLE→FETCH→HIGH).
- Each instruction occupies 3 cycles (FETCH, HIGH, LOW). `Instruction` is stable from FETCH+1 through the end of LOW.
- A run of N instructions with no HALT takes 3N+2 cycles from `Start` to `Done`, inclusive of IDLE exit.
- Reset asserted while `CpuClk`=1 drives `CpuClk` low asynchronously. That falling edge may cause a spurious CPU write; CPU register contents are undefined after a mid-run reset.
- A load written at cycle t is visible to a FETCH at cycle t+1.

## Configuration
- `SEQ_LOOP_EN` defined: in LOW, PC+1==len wraps PC to 0 and continues with FETCH instead of going to DONE. The run ends only on `Stop` or a HALT opcode. `IssueCount` still saturates at 255.
- `SEQ_LOOP_EN` undefined: the run ends at len as described above. No loop logic is present.

## Structure
- Package `seq_pkg`:
  - State enum (IDLE, FETCH, HIGH, LOW, DONE).
  - `OP_HALT`=3'b111.
  - CPU opcode constants: ADD 000, SUB 001, AND 010, OR 011, SLT 100, LI 101.
- Sub-module `seq_prog_mem`: `DEPTH`x`IW` storage with one synchronous write port and one combinational read port, no reset.

## Test plan
- Load `101011101`, `101010110`, `001011011`; `ProgLen`=3; `Start`. Expect:
  - `CpuClk` pulses 3 times; CPU `WriteData` shows 7, 5, 2.
  - `Done` at cycle 11; `IssueCount`=3.
- `ProgLen`=0, `Start`: `Done` 1 cycle later; `CpuClk` never rises; `IssueCount`=0.
- `mem[1]`=`111000000`, `ProgLen`=4: exactly 1 instruction issued; `Done` with `PC`=1.
- `Stop` asserted during the HIGH of instruction 2 of 5: instruction 2 completes through LOW; `IssueCount`=2; no third `CpuClk` rise.
- `LoadEn` to address 0 while `Busy`: `mem[0]` is unchanged on readback after the run. `Start` pulsed mid-run: no restart, PC continues.
- `RST_N` low during HIGH: all outputs return to reset values immediately; the next `Start` runs from PC=0 with memory intact.
